// File: rtl/apb_forwarding_slave_if.sv
// APB bus bundle shared by the core's imem master and the forwarding slave.
interface apb_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_W-1:0]     paddr;
   logic [DATA_W-1:0]     pwdata;
   logic [DATA_W/8-1:0]   pstrb;
   logic [DATA_W-1:0]     prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata, pstrb,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata, pstrb,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_forwarding_slave.sv
// Zero-wait APB completer standing in for instruction memory: reads return `forward`, the last
// SETUP address is exported on `requested`. Optional macro APB_FWD_WRITE_ERR_EN flags writes.
module apb_forwarding_slave #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   apb_if.slave              apb,
   input  logic [DATA_W-1:0] forward,
   output logic [ADDR_W-1:0] requested
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } phase_e;

   phase_e            phase_q, phase_d;
   logic [ADDR_W-1:0] requested_q, requested_d;
   logic              inReset;
   logic              setupPhase;
   logic              accessPhase;
   logic              unusedBits;

   // rst_n keeps its historical name but is active-high.
   assign inReset     = rst_n;
   assign setupPhase  = apb.psel & ~apb.penable;
   assign accessPhase = apb.psel & apb.penable;
   assign unusedBits  = ^{apb.pwdata, apb.pstrb};

   always_ff @(posedge clk) begin
      if (inReset) begin
         phase_q     <= IDLE;
         requested_q <= '0;
      end else begin
         phase_q     <= phase_d;
         requested_q <= requested_d;
      end
   end

   // Capture depends only on the bus, so an ACCESS without SETUP never updates `requested`.
   always_comb begin
      phase_d     = phase_q;
      requested_d = requested_q;
      if (setupPhase) begin
         requested_d = apb.paddr;
      end
      case (phase_q)
         IDLE:    phase_d = setupPhase ? SETUP : IDLE;
         SETUP:   phase_d = ACCESS;
         ACCESS:  phase_d = setupPhase ? SETUP : IDLE;
         default: phase_d = IDLE;
      endcase
   end

   // Responses come straight from the bus so protocol violations are still answered.
   always_comb begin
      apb.pready  = 1'b0;
      apb.prdata  = '0;
      apb.pslverr = 1'b0;
      if (!inReset && accessPhase) begin
         apb.pready = 1'b1;
         if (!apb.pwrite) begin
            apb.prdata = forward;
         end
`ifdef APB_FWD_WRITE_ERR_EN
         else begin
            apb.pslverr = 1'b1;
         end
`endif
      end
   end

   assign requested = requested_q;
endmodule

// File: tb/tb_apb_forwarding_slave.sv
// Self-checking bench for apb_forwarding_slave: directed vector table, hand-written reset and
// forwarding sequences, then random bus traffic against a rule-level reference model.
module tb_apb_forwarding_slave;
`ifdef APB_FWD_WRITE_ERR_EN
   localparam logic WERR = 1'b1;
`else
   localparam logic WERR = 1'b0;
`endif

   typedef struct {
      logic        psel;
      logic        penable;
      logic        pwrite;
      logic [31:0] paddr;
      logic [31:0] pwdata;
      logic [31:0] fwd;
      logic        expPready;
      logic [31:0] expPrdata;
      logic        expPslverr;
      logic [31:0] expRequested;
   } vector_t;

   logic        clk;
   logic        rstN;
   logic [31:0] forward;
   logic [31:0] requested;
   int          compared;
   int          mismatched;
   vector_t     vecs[$];

   apb_if #(.ADDR_W(32), .DATA_W(32)) apbBus ();

   apb_forwarding_slave #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk       (clk),
      .rst_n     (rstN),
      .apb       (apbBus),
      .forward   (forward),
      .requested (requested)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic rst, input logic psel, input logic penable,
                                input logic pwrite, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] fwd);
      rstN           = rst;
      apbBus.psel    = psel;
      apbBus.penable = penable;
      apbBus.pwrite  = pwrite;
      apbBus.paddr   = addr;
      apbBus.pwdata  = wdata;
      apbBus.pstrb   = 4'hF;
      forward        = fwd;
   endtask

   task automatic checkOne(input string tag, input logic [31:0] actual, input logic [31:0] required);
      compared++;
      if (actual !== required) begin
         mismatched++;
         $display("[TB] FAIL %s actual=0x%08h required=0x%08h", tag, actual, required);
      end
   endtask

   task automatic checkOutput(input string tag, input logic expPready, input logic [31:0] expPrdata,
                              input logic expPslverr, input logic [31:0] expReq);
      checkOne({tag, ".pready"},    {31'd0, apbBus.pready},  {31'd0, expPready});
      checkOne({tag, ".prdata"},    apbBus.prdata,           expPrdata);
      checkOne({tag, ".pslverr"},   {31'd0, apbBus.pslverr}, {31'd0, expPslverr});
      checkOne({tag, ".requested"}, requested,               expReq);
   endtask

   task automatic addVec(input logic psel, input logic penable, input logic pwrite,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] fwd,
                         input logic expPready, input logic [31:0] expPrdata,
                         input logic expPslverr, input logic [31:0] expReq);
      vector_t v;
      v.psel = psel; v.penable = penable; v.pwrite = pwrite;
      v.paddr = addr; v.pwdata = wdata; v.fwd = fwd;
      v.expPready = expPready; v.expPrdata = expPrdata;
      v.expPslverr = expPslverr; v.expRequested = expReq;
      vecs.push_back(v);
   endtask

   initial begin
      logic [31:0] modelReq;
      logic        rRst, rSel, rEn, rWr;
      logic [31:0] rAddr, rFwd;
      logic        expRdy;

      compared   = 0;
      mismatched = 0;

      // One row per cycle; requested reflects all earlier edges.
      addVec(1, 0, 0, 32'h0000_0008, 32'h0, 32'h3E80_0093, 0, 32'h0,          0,    32'h40);
      addVec(1, 1, 0, 32'h0000_0008, 32'h0, 32'h3E80_0093, 1, 32'h3E80_0093, 0,    32'h8);
      addVec(1, 0, 0, 32'h0000_0000, 32'h0, 32'h0,         0, 32'h0,          0,    32'h8);
      addVec(1, 1, 0, 32'h0000_0000, 32'h0, 32'h13,        1, 32'h13,         0,    32'h0);
      addVec(1, 0, 0, 32'h0000_0004, 32'h0, 32'h13,        0, 32'h0,          0,    32'h0);
      addVec(1, 1, 0, 32'h0000_0004, 32'h0, 32'h7D00_8113, 1, 32'h7D00_8113, 0,    32'h4);
      addVec(1, 0, 0, 32'h0000_0008, 32'h0, 32'h7D00_8113, 0, 32'h0,          0,    32'h4);
      addVec(1, 1, 0, 32'h0000_0008, 32'h0, 32'hC181_0193, 1, 32'hC181_0193, 0,    32'h8);
      addVec(1, 0, 1, 32'h0000_0018, 32'hAAAA_AAAA, 32'hDEAD_BEEF, 0, 32'h0,  0,    32'h8);
      addVec(1, 1, 1, 32'h0000_0018, 32'hAAAA_AAAA, 32'hDEAD_BEEF, 1, 32'h0,  WERR, 32'h18);
      addVec(1, 0, 0, 32'h0004_0D80, 32'h0, 32'h1234_5678, 0, 32'h0,          0,    32'h18);
      addVec(1, 1, 0, 32'h0004_0D80, 32'h0, 32'h1234_5678, 1, 32'h1234_5678, 0,    32'h0004_0D80);
      for (int k = 0; k < 5; k++)
         addVec(0, 0, 0, 32'hFFFF_FFFC, 32'h0, 32'hCAFE_F00D, 0, 32'h0,       0,    32'h0004_0D80);
      addVec(1, 1, 0, 32'h0000_0500, 32'h0, 32'h0BAD_C0DE, 1, 32'h0BAD_C0DE, 0,    32'h0004_0D80);
      addVec(0, 0, 0, 32'h0000_0500, 32'h0, 32'h0BAD_C0DE, 0, 32'h0,          0,    32'h0004_0D80);
      addVec(1, 0, 0, 32'h0000_0003, 32'h0, 32'h11,        0, 32'h0,          0,    32'h0004_0D80);
      addVec(1, 1, 0, 32'h0000_0003, 32'h0, 32'h11,        1, 32'h11,         0,    32'h3);
      addVec(0, 1, 0, 32'h0000_0003, 32'h0, 32'h11,        0, 32'h0,          0,    32'h3);

      // Reset held for two edges with a SETUP on the bus.
      applyStimulus(1, 1, 0, 0, 32'h40, 32'h0, 32'h55);
      #1 checkOutput("reset0", 0, 32'h0, 0, 32'h0);
      @(negedge clk);
      #1 checkOutput("reset1", 0, 32'h0, 0, 32'h0);
      @(negedge clk);
      applyStimulus(0, 1, 0, 0, 32'h40, 32'h0, 32'h55);
      #1 checkOutput("release", 0, 32'h0, 0, 32'h0);

      foreach (vecs[i]) begin
         @(negedge clk);
         applyStimulus(0, vecs[i].psel, vecs[i].penable, vecs[i].pwrite, vecs[i].paddr,
                       vecs[i].pwdata, vecs[i].fwd);
         #1 checkOutput($sformatf("vec%0d", i), vecs[i].expPready, vecs[i].expPrdata,
                        vecs[i].expPslverr, vecs[i].expRequested);
      end

      // Reset during ACCESS aborts the transfer and clears requested.
      @(negedge clk);
      applyStimulus(0, 1, 0, 0, 32'h100, 32'h0, 32'h77);
      #1 checkOutput("abortSetup", 0, 32'h0, 0, 32'h3);
      @(negedge clk);
      applyStimulus(1, 1, 1, 0, 32'h100, 32'h0, 32'h77);
      #1 checkOutput("abortAccess", 0, 32'h0, 0, 32'h100);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 32'h100, 32'h0, 32'h77);
      #1 checkOutput("abortAfter", 0, 32'h0, 0, 32'h0);

      // forward changing inside the ACCESS cycle reaches prdata without a clock edge.
      @(negedge clk);
      applyStimulus(0, 1, 0, 0, 32'hC, 32'h0, 32'h13);
      #1 checkOutput("midSetup", 0, 32'h0, 0, 32'h0);
      @(negedge clk);
      applyStimulus(0, 1, 1, 0, 32'hC, 32'h0, 32'h13);
      #1 checkOutput("midAccessA", 1, 32'h13, 0, 32'hC);
      #2 forward = 32'h0640_006F;
      #1 checkOutput("midAccessB", 1, 32'h0640_006F, 0, 32'hC);

      modelReq = 32'hC;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         rRst  = ($urandom_range(0, 15) == 0);
         rSel  = ($urandom_range(0, 3) != 0);
         rEn   = $urandom_range(0, 1) == 1;
         rWr   = $urandom_range(0, 1) == 1;
         rAddr = $urandom;
         rFwd  = $urandom;
         applyStimulus(rRst, rSel, rEn, rWr, rAddr, $urandom, rFwd);
         expRdy = !rRst && rSel && rEn;
         #1 checkOutput($sformatf("rand%0d", n), expRdy, (expRdy && !rWr) ? rFwd : 32'h0,
                        expRdy && rWr && WERR, modelReq);
         if (rRst)
            modelReq = 32'h0;
         else if (rSel && !rEn)
            modelReq = rAddr;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
